// File: rtl/sprite_position_ctrl_if.sv
// Bundles the frame/button inputs and coordinate outputs of sprite_position_ctrl.
// master = stimulus/VGA side, slave = the position controller.
interface sprite_position_ctrl_if;
    logic        vsync;
    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic        btn_center;
    logic [15:0] xCoordinate;
    logic [15:0] yCoordinate;
    logic        moving;

    modport master (
        output vsync, btn_up, btn_down, btn_left, btn_right, btn_center,
        input  xCoordinate, yCoordinate, moving
    );

    modport slave (
        input  vsync, btn_up, btn_down, btn_left, btn_right, btn_center,
        output xCoordinate, yCoordinate, moving
    );
endinterface

// File: rtl/sprite_position_ctrl.sv
// Frame-synchronous sprite position controller: latches button requests and commits
// one clamped step per vsync. Define POS_WRAP_EN to wrap at the edges instead of clamping.
module sprite_position_ctrl #(
    parameter int HD     = 640,
    parameter int VD     = 480,
    parameter int SPRITE = 12,
    parameter int STEP   = 4,
    parameter int X_INIT = 314,
    parameter int Y_INIT = 234
) (
    input  logic                 clk,
    input  logic                 reset,
    sprite_position_ctrl_if.slave bus
);

    localparam logic signed [11:0] C_XMAX  = 12'(HD - SPRITE);
    localparam logic signed [11:0] C_YMAX  = 12'(VD - SPRITE);
    localparam logic signed [11:0] C_STEP  = 12'(STEP);
    localparam logic        [9:0]  C_XINIT = 10'(X_INIT);
    localparam logic        [9:0]  C_YINIT = 10'(Y_INIT);

    typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_calc;
    logic        w_commit;
    logic [5:0]  w_async;
    logic [5:0]  r_meta;
    logic [5:0]  r_sync;
    logic        r_vsync_d;
    logic        r_tick;
    logic        w_tick;
    logic [4:0]  r_req;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic [9:0]  r_nx;
    logic [9:0]  r_ny;
    logic [9:0]  w_nx;
    logic [9:0]  w_ny;
    logic        r_moving;

    // Bit order {center, right, left, down, up, vsync}; r_req drops the vsync bit.
    assign w_async = {bus.btn_center, bus.btn_right, bus.btn_left,
                      bus.btn_down, bus.btn_up, bus.vsync};
    assign w_tick  = r_sync[0] & ~r_vsync_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta    <= '0;
            r_sync    <= '0;
            r_vsync_d <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_meta    <= w_async;
            r_sync    <= r_meta;
            r_vsync_d <= r_sync[0];
            r_tick    <= w_tick;
        end
    end

    // A button still active during COMMIT survives the clear and carries to the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req <= '0;
        end else if (w_commit) begin
            r_req <= r_sync[5:1];
        end else begin
            r_req <= r_req | r_sync[5:1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_calc       = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE:    if (r_tick) w_state_next = CALC;
            CALC: begin
                w_calc       = 1'b1;
                w_state_next = COMMIT;
            end
            COMMIT: begin
                w_commit     = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    function automatic logic [9:0] f_axis(input logic [9:0] pos, input logic dec,
                                          input logic inc, input logic signed [11:0] maxv);
        logic signed [11:0] p;
        logic signed [11:0] d;
        logic signed [11:0] u;
        logic signed [11:0] res;
        p   = signed'({2'b00, pos});
        d   = p - C_STEP;
        u   = p + C_STEP;
        res = p;
`ifdef POS_WRAP_EN
        if (dec && !inc) res = (d < 0) ? maxv : d;
        if (inc && !dec) res = (u > maxv) ? 12'sd0 : u;
`else
        if (dec && !inc) res = (d < 0) ? 12'sd0 : d;
        if (inc && !dec) res = (u > maxv) ? maxv : u;
`endif
        f_axis = 10'(res);
    endfunction

    always_comb begin
        w_nx = C_XINIT;
        w_ny = C_YINIT;
        if (!r_req[4]) begin
            w_nx = f_axis(r_x, r_req[2], r_req[3], C_XMAX);
            w_ny = f_axis(r_y, r_req[0], r_req[1], C_YMAX);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nx     <= C_XINIT;
            r_ny     <= C_YINIT;
            r_x      <= C_XINIT;
            r_y      <= C_YINIT;
            r_moving <= 1'b0;
        end else begin
            if (w_calc) begin
                r_nx <= w_nx;
                r_ny <= w_ny;
            end
            r_moving <= 1'b0;
            if (w_commit) begin
                r_x      <= r_nx;
                r_y      <= r_ny;
                r_moving <= (r_nx != r_x) || (r_ny != r_y);
            end
        end
    end

    assign bus.xCoordinate = {6'b000000, r_x};
    assign bus.yCoordinate = {6'b000000, r_y};
    assign bus.moving      = r_moving;

endmodule

// File: tb/tb_sprite_position_ctrl.sv
// Directed and randomized bench for sprite_position_ctrl against a frame-level position model.
module tb_sprite_position_ctrl;

    localparam int XMAX = 628;
    localparam int YMAX = 468;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    sprite_position_ctrl_if bus ();

    sprite_position_ctrl #(
        .HD(640), .VD(480), .SPRITE(12), .STEP(4), .X_INIT(314), .Y_INIT(234)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;
    int mx, my;
    logic [4:0] pend;   // {center,right,left,down,up} requests seen since last commit
    logic [4:0] held;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int axis(input int v, input bit dec, input bit inc, input int maxv);
        int n;
        if (dec == inc) return v;
        n = dec ? v - 4 : v + 4;
`ifdef POS_WRAP_EN
        if (n < 0) return maxv;
        if (n > maxv) return 0;
`else
        if (n < 0) return 0;
        if (n > maxv) return maxv;
`endif
        return n;
    endfunction

    task automatic set_btn(input logic [4:0] m);
        bus.btn_up     = m[0];
        bus.btn_down   = m[1];
        bus.btn_left   = m[2];
        bus.btn_right  = m[3];
        bus.btn_center = m[4];
    endtask

    task automatic press(input logic [4:0] m);
        set_btn(m | held);
        repeat (3) @(posedge clk);
        #1 set_btn(held);
        pend = pend | m;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [4:0] m);
        held = m;
        set_btn(m);
        pend = pend | m;
    endtask

    // One vsync pulse; checks outputs before, at and after the commit edge.
    task automatic frame(input string tag);
        logic [4:0] p;
        int nx, ny;
        bit mv;
        p = pend | held;
        if (p[4]) begin
            nx = 314;
            ny = 234;
        end else begin
            nx = axis(mx, p[2], p[3], XMAX);
            ny = axis(my, p[0], p[1], YMAX);
        end
        mv = (nx != mx) || (ny != my);
        repeat (2) @(posedge clk);
        #1 bus.vsync = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_x_pre"}, bus.xCoordinate, 16'(mx));
        chk({tag, "_y_pre"}, bus.yCoordinate, 16'(my));
        chk({tag, "_mv_pre"}, 16'(bus.moving), 16'd0);
        bus.vsync = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_x"}, bus.xCoordinate, 16'(nx));
        chk({tag, "_y"}, bus.yCoordinate, 16'(ny));
        chk({tag, "_mv"}, 16'(bus.moving), 16'(mv));
        @(posedge clk);
        #1;
        chk({tag, "_mv_post"}, 16'(bus.moving), 16'd0);
        mx   = nx;
        my   = ny;
        pend = held;
    endtask

    initial begin
        int seq_exp [3];
        int guard;
        logic [4:0] m;

        reset = 1'b1;
        bus.vsync = 1'b0;
        held = '0;
        pend = '0;
        set_btn('0);
        mx = 314;
        my = 234;

        // Reset and idle frames
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_x", bus.xCoordinate, 16'd314);
        chk("rst_y", bus.yCoordinate, 16'd234);
        chk("rst_mv", 16'(bus.moving), 16'd0);
        for (int i = 0; i < 3; i++) frame("idle");

        // Single right step, then quiet frame
        press(5'b01000);
        frame("right");
        chk("right_abs", bus.xCoordinate, 16'd318);
        frame("right_quiet");

        // Walk left to x=6, then across the left edge
        hold(5'b00100);
        guard = 0;
        while (mx != 6 && guard < 200) begin
            frame("walk");
            guard++;
        end
        chk("walk_reached", 16'(mx), 16'd6);
`ifdef POS_WRAP_EN
        seq_exp = '{2, 628, 624};
`else
        seq_exp = '{2, 0, 0};
`endif
        for (int i = 0; i < 3; i++) begin
            frame("edge");
            chk("edge_abs", bus.xCoordinate, 16'(seq_exp[i]));
        end
        hold('0);
        frame("edge_release");
        frame("edge_quiet");

        // Opposing and diagonal requests
        press(5'b00011);
        frame("updown");
        press(5'b01001);
        frame("diag");

        // Recenter overrides a pending direction
        press(5'b01000);
        press(5'b10000);
        frame("center");
        chk("center_x", bus.xCoordinate, 16'd314);
        chk("center_y", bus.yCoordinate, 16'd234);
        frame("center_quiet");

        // Random request mixes
        for (int i = 0; i < 30; i++) begin
            m = 5'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) m[4] = 1'b1;
            if ($urandom_range(0, 3) != 0) press(m);
            frame("rand");
        end

        // Reset while in CALC with a left request latched
        press(5'b01000);
        frame("pre_reset");
        press(5'b00100);
        repeat (2) @(posedge clk);
        #1 bus.vsync = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        bus.vsync = 1'b0;
        #1;
        chk("midrst_x", bus.xCoordinate, 16'd314);
        chk("midrst_y", bus.yCoordinate, 16'd234);
        chk("midrst_mv", 16'(bus.moving), 16'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        mx = 314;
        my = 234;
        pend = '0;
        frame("post_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
